ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one single-port RAM (shared address, write strobe, read enable, combinational read data) between two requesters, A and B.
- Each requester uses a req/ack command handshake.
- Per transaction: arbitrate, register the winner's command, drive the RAM for exactly one cycle, return read data with a valid pulse.
- Sits between client logic (e.g. UART loader, display scanner) and the RAM instance. Round-robin fairness by default.

Parameters:
WIDTH, 16, RAM data width in bits
DEPTH, 256, RAM depth in words; address width AW = $clog2(DEPTH)

Ports:
i_Clk  in  1  clock; all logic on rising edge
i_Rst  in  1  synchronous, active-high reset
i_A_Req  in  1  A command request; held until o_A_Ack
i_A_Wr  in  1  A command type: 1 = write, 0 = read
i_A_Addr  in  AW  A word address
i_A_Wr_Data  in  WIDTH  A write data
o_A_Ack  out  1  one-cycle pulse: A command accepted and issued to RAM this cycle
o_A_Rd_DV  out  1  one-cycle pulse: o_A_Rd_Data valid
o_A_Rd_Data  out  WIDTH  A read data; held until next A read completes
i_B_Req, i_B_Wr, i_B_Addr, i_B_Wr_Data, o_B_Ack, o_B_Rd_DV, o_B_Rd_Data  same as A, for requester B
o_Ram_Addr  out  AW  RAM shared address
o_Ram_Wr_DV  out  1  RAM write strobe
o_Ram_Wr_Data  out  WIDTH  RAM write data
o_Ram_Rd_En  out  1  RAM read enable
i_Ram_Rd_Data  in  WIDTH  RAM read data; combinational on o_Ram_Addr

Behaviour:
- Reset: state IDLE; RR pointer prefers A. All of the following are 0: o_Ram_Addr, o_Ram_Wr_Data, o_Ram_Wr_DV, o_Ram_Rd_En, o_A_Ack, o_B_Ack, o_A_Rd_DV, o_B_Rd_DV, o_A_Rd_Data, o_B_Rd_Data.
- Reset asserted in any state overrides everything and returns to reset values next edge. An in-flight command is dropped: no ack, no Rd_DV. A RAM strobe already driven in that cycle is not retracted.
- FSM states: IDLE, ISSUE. All outputs are registered.
- IDLE, cycle N:
  - No request: stay in IDLE.
  - Only one requester asserting: it wins.
  - Both asserting: winner is the RR-preferred port.
  - At edge: latch winner's Addr, Wr_Data and Wr into the RAM output registers; Wr_DV = Wr, Rd_En = ~Wr; assert the winner's Ack; record winner id; RR pointer prefers the other port; go to ISSUE.
- ISSUE, cycle N+1:
  - RAM strobes and the winner's Ack are high for exactly this cycle.
  - For a read, i_Ram_Rd_Data is captured at the end of this cycle into the winner's Rd_Data; Rd_DV pulses in cycle N+2.
  - At edge: strobes and Ack go to 0; next state IDLE unconditionally.
  - Requests are not sampled in ISSUE; a requester may leave Req high to queue its next command.
- Throughput: at most one command per 2 cycles.
- Read latency: Req sampled at edge N → Rd_DV and data at cycle N+2.
- Write completes at the end of cycle N+1.
- Ordering:
  - A write at cycle N+1 followed by a read of the same address granted next reads the new data.
  - A read and write are never issued in the same cycle.
- o_Ram_Addr and o_Ram_Wr_Data hold their last values while idle. Rd_Data for a port is unchanged by the other port's reads and by writes.
- Alternation: with both Req held high continuously, grants strictly alternate A,B,A,B starting with A after reset.

Optional Feature:
- Macro RAM_ARB_FIXED_PRIO_EN.
- Defined: RR pointer removed; A always wins when both request. B is granted only in IDLE cycles with i_A_Req low. B can starve.
- Undefined: round-robin as above.
- Port list and timing are identical in both builds.

Test Plan:
1. Reset then A write (Addr 0x10, Data 0xBEEF):
   - o_A_Ack 1 cycle after Req sampled, coincident with o_Ram_Wr_DV=1, o_Ram_Addr=0x10, o_Ram_Wr_Data=0xBEEF, o_Ram_Rd_En=0.
   - No Rd_DV.
2. A read of 0x10 after step 1, against a RAM model:
   - o_Ram_Rd_En pulses at N+1.
   - o_A_Rd_DV pulses at N+2 with o_A_Rd_Data=0xBEEF.
   - o_B_Rd_Data stays 0.
3. A and B both hold Req for 8 cycles (reads of 0x01 and 0x02):
   - Acks alternate A,B,A,B, one grant every 2 cycles.
   - Each Rd_DV goes only to its own port with the correct data.
4. B write 0x20=0x1234 then A read 0x20 back-to-back:
   - A's read returns 0x1234 (write-before-read ordering).
5. i_Rst asserted in ISSUE of an A read:
   - Next cycle all outputs 0, no o_A_Rd_DV.
   - After release with both Req high, A granted first.
6. Build with RAM_ARB_FIXED_PRIO_EN, both Req held high 10 cycles:
   - Only A acked.
   - Drop A Req → B acked within 2 cycles.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port RAM.
// Round-robin by default; define RAM_ARB_FIXED_PRIO_EN for fixed A-over-B priority.
module ram_port_arbiter #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_A_Req,
  input  logic             i_A_Wr,
  input  logic [AW-1:0]    i_A_Addr,
  input  logic [WIDTH-1:0] i_A_Wr_Data,
  output logic             o_A_Ack,
  output logic             o_A_Rd_DV,
  output logic [WIDTH-1:0] o_A_Rd_Data,
  input  logic             i_B_Req,
  input  logic             i_B_Wr,
  input  logic [AW-1:0]    i_B_Addr,
  input  logic [WIDTH-1:0] i_B_Wr_Data,
  output logic             o_B_Ack,
  output logic             o_B_Rd_DV,
  output logic [WIDTH-1:0] o_B_Rd_Data,
  output logic [AW-1:0]    o_Ram_Addr,
  output logic             o_Ram_Wr_DV,
  output logic [WIDTH-1:0] o_Ram_Wr_Data,
  output logic             o_Ram_Rd_En,
  input  logic [WIDTH-1:0] i_Ram_Rd_Data
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             wr_dv_q, wr_dv_d;
  logic             rd_en_q, rd_en_d;
  logic             a_ack_q, a_ack_d;
  logic             b_ack_q, b_ack_d;
  logic             win_b_q, win_b_d;
  logic             a_dv_q, a_dv_d;
  logic             b_dv_q, b_dv_d;
  logic [WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [WIDTH-1:0] b_rdata_q, b_rdata_d;
  logic             grant_a, grant_b;

`ifdef RAM_ARB_FIXED_PRIO_EN
  // A always wins a tie; B only gets idle cycles A leaves empty
  always_comb begin
    grant_a = i_A_Req;
    grant_b = i_B_Req & ~i_A_Req;
  end
`else
  logic rr_a_q, rr_a_d;

  // Tie goes to whichever port the round-robin pointer favours
  always_comb begin
    grant_a = i_A_Req & (~i_B_Req | rr_a_q);
    grant_b = i_B_Req & ~grant_a;
  end
`endif

  // Next-state and next-output decode; every output is registered
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_dv_d   = 1'b0;
    rd_en_d   = 1'b0;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    win_b_d   = win_b_q;
    a_dv_d    = 1'b0;
    b_dv_d    = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
    rr_a_d    = rr_a_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_a) begin
          addr_d  = i_A_Addr;
          wdata_d = i_A_Wr_Data;
          wr_dv_d = i_A_Wr;
          rd_en_d = ~i_A_Wr;
          a_ack_d = 1'b1;
          win_b_d = 1'b0;
          state_d = ISSUE;
`ifndef RAM_ARB_FIXED_PRIO_EN
          rr_a_d  = 1'b0;
`endif
        end else if (grant_b) begin
          addr_d  = i_B_Addr;
          wdata_d = i_B_Wr_Data;
          wr_dv_d = i_B_Wr;
          rd_en_d = ~i_B_Wr;
          b_ack_d = 1'b1;
          win_b_d = 1'b1;
          state_d = ISSUE;
`ifndef RAM_ARB_FIXED_PRIO_EN
          rr_a_d  = 1'b1;
`endif
        end
      end
      ISSUE: begin
        state_d = IDLE;
        if (rd_en_q) begin
          if (win_b_q) begin
            b_rdata_d = i_Ram_Rd_Data;
            b_dv_d    = 1'b1;
          end else begin
            a_rdata_d = i_Ram_Rd_Data;
            a_dv_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_dv_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      win_b_q   <= 1'b0;
      a_dv_q    <= 1'b0;
      b_dv_q    <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      rr_a_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_dv_q   <= wr_dv_d;
      rd_en_q   <= rd_en_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      win_b_q   <= win_b_d;
      a_dv_q    <= a_dv_d;
      b_dv_q    <= b_dv_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
      rr_a_q    <= rr_a_d;
`endif
    end
  end

  assign o_Ram_Addr    = addr_q;
  assign o_Ram_Wr_Data = wdata_q;
  assign o_Ram_Wr_DV   = wr_dv_q;
  assign o_Ram_Rd_En   = rd_en_q;
  assign o_A_Ack       = a_ack_q;
  assign o_B_Ack       = b_ack_q;
  assign o_A_Rd_DV     = a_dv_q;
  assign o_B_Rd_DV     = b_dv_q;
  assign o_A_Rd_Data   = a_rdata_q;
  assign o_B_Rd_Data   = b_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM model, transaction table, read-data scoreboard.
// Fixed-priority sequence runs when RAM_ARB_FIXED_PRIO_EN is defined.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_wr, b_req, b_wr;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, a_dv, b_ack, b_dv;
  logic [15:0] a_rdata, b_rdata;
  logic [7:0]  ram_addr;
  logic        ram_wr, ram_rd;
  logic [15:0] ram_wdata, ram_rdata;

  logic [15:0] mem [256];
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] a_hold, b_hold;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          pb;
    bit          wr;
    logic [7:0]  addr;
    logic [15:0] data;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  ram_port_arbiter #(.WIDTH(16), .DEPTH(256)) dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_A_Req(a_req), .i_A_Wr(a_wr), .i_A_Addr(a_addr),
    .i_A_Wr_Data(a_wdata), .o_A_Ack(a_ack), .o_A_Rd_DV(a_dv),
    .o_A_Rd_Data(a_rdata),
    .i_B_Req(b_req), .i_B_Wr(b_wr), .i_B_Addr(b_addr),
    .i_B_Wr_Data(b_wdata), .o_B_Ack(b_ack), .o_B_Rd_DV(b_dv),
    .o_B_Rd_Data(b_rdata),
    .o_Ram_Addr(ram_addr), .o_Ram_Wr_DV(ram_wr),
    .o_Ram_Wr_Data(ram_wdata), .o_Ram_Rd_En(ram_rd),
    .i_Ram_Rd_Data(ram_rdata)
  );

  always @(posedge clk)
    if (ram_wr) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("rw_exclusive", {31'd0, ram_wr & ram_rd}, 32'd0);
    if (a_dv) begin
      if (qa.size() == 0) chk("a_dv_unexpected", 32'd1, 32'd0);
      else begin
        a_hold = qa.pop_front();
        chk("a_rd_data", {16'd0, a_rdata}, {16'd0, a_hold});
      end
    end
    if (b_dv) begin
      if (qb.size() == 0) chk("b_dv_unexpected", 32'd1, 32'd0);
      else begin
        b_hold = qb.pop_front();
        chk("b_rd_data", {16'd0, b_rdata}, {16'd0, b_hold});
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    a_req = 0; b_req = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    a_hold = '0;
    b_hold = '0;
  endtask

  task automatic wait_ack(input bit pb, output int lat);
    lat = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pb ? b_ack : a_ack) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic txn(input vec_t v);
    int lat;
    if (v.pb) begin
      b_req = 1; b_wr = v.wr; b_addr = v.addr; b_wdata = v.data;
    end else begin
      a_req = 1; a_wr = v.wr; a_addr = v.addr; a_wdata = v.data;
    end
    wait_ack(v.pb, lat);
    chk("ack_latency", lat, 1);
    chk("other_ack", {31'd0, v.pb ? a_ack : b_ack}, 32'd0);
    chk("ram_addr", {24'd0, ram_addr}, {24'd0, v.addr});
    chk("ram_strobes", {30'd0, ram_wr, ram_rd}, {30'd0, v.wr, ~v.wr});
    if (v.wr) chk("ram_wdata", {16'd0, ram_wdata}, {16'd0, v.data});
    else if (v.pb) qb.push_back(mem_exp(v.addr));
    else qa.push_back(mem_exp(v.addr));
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
    @(posedge clk); #1;
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    chk("a_hold", {16'd0, a_rdata}, {16'd0, a_hold});
    chk("b_hold", {16'd0, b_rdata}, {16'd0, b_hold});
  endtask

  logic [15:0] shadow [256];

  function automatic logic [15:0] mem_exp(input logic [7:0] ad);
    return shadow[ad];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    vecs[0] = '{0, 1, 8'h10, 16'hBEEF};
    vecs[1] = '{0, 0, 8'h10, 16'h0000};
    vecs[2] = '{0, 1, 8'h01, 16'h1111};
    vecs[3] = '{1, 1, 8'h02, 16'h2222};
    vecs[4] = '{1, 0, 8'h10, 16'h0000};
    vecs[5] = '{0, 1, 8'hFF, 16'h0001};
    vecs[6] = '{1, 0, 8'hFF, 16'h0000};
    vecs[7] = '{0, 1, 8'h00, 16'hFFFF};
    vecs[8] = '{0, 0, 8'h00, 16'h0000};
    vecs[9] = '{0, 0, 8'h01, 16'h0000};
    a_wr = 0; b_wr = 0;
    a_addr = 0; b_addr = 0;
    a_wdata = 0; b_wdata = 0;

    rst = 1'b1;
    a_req = 0; b_req = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ram", {ram_addr, ram_wdata, 6'd0, ram_wr, ram_rd}, 32'd0);
    chk("rst_ctl", {28'd0, a_ack, b_ack, a_dv, b_dv}, 32'd0);
    chk("rst_rdata", {a_rdata, b_rdata}, 32'd0);
    do_reset();

    foreach (vecs[i]) begin
      if (vecs[i].wr) shadow[vecs[i].addr] = vecs[i].data;
      txn(vecs[i]);
    end

    b_req = 1; b_wr = 1; b_addr = 8'h20; b_wdata = 16'h1234;
    shadow[8'h20] = 16'h1234;
    wait_ack(1, lat);
    chk("b2b_b_lat", lat, 1);
    @(posedge clk); #1;
    b_req = 0;
    a_req = 1; a_wr = 0; a_addr = 8'h20;
    qa.push_back(16'h1234);
    wait_ack(0, lat);
    chk("b2b_a_lat", lat, 1);
    chk("b2b_rd_en", {31'd0, ram_rd}, 32'd1);
    @(posedge clk); #1;
    a_req = 0;
    @(posedge clk); #1;
    chk("b2b_a_drained", qa.size(), 0);
    chk("b2b_a_hold", {16'd0, a_rdata}, 32'h1234);

`ifndef RAM_ARB_FIXED_PRIO_EN
    do_reset();
    a_req = 1; a_wr = 0; a_addr = 8'h01;
    b_req = 1; b_wr = 0; b_addr = 8'h02;
    qa.push_back(16'h1111); qa.push_back(16'h1111);
    qb.push_back(16'h2222); qb.push_back(16'h2222);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("alt_a_ack", {31'd0, a_ack}, {31'd0, i % 4 == 1});
      chk("alt_b_ack", {31'd0, b_ack}, {31'd0, i % 4 == 3});
    end
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("alt_a_drained", qa.size(), 0);
    chk("alt_b_drained", qb.size(), 0);
`else
    do_reset();
    a_req = 1; a_wr = 1; a_addr = 8'h40; a_wdata = 16'hAAAA;
    b_req = 1; b_wr = 1; b_addr = 8'h41; b_wdata = 16'hBBBB;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("fp_a_ack", {31'd0, a_ack}, {31'd0, i % 2 == 1});
      chk("fp_b_ack", {31'd0, b_ack}, 32'd0);
    end
    @(posedge clk); #1;
    a_req = 0;
    wait_ack(1, lat);
    chk("fp_b_granted", {31'd0, lat >= 0 && lat <= 2}, 32'd1);
    @(posedge clk); #1;
    b_req = 0;
    repeat (2) @(posedge clk);
    #1;
`endif

    do_reset();
    a_req = 1; a_wr = 0; a_addr = 8'h10;
    @(negedge clk);
    @(posedge clk); #1;
    a_req = 0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_issue_ack", {31'd0, a_ack}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    a_hold = '0; b_hold = '0;
    a_req = 1; a_wr = 1; a_addr = 8'h30; a_wdata = 16'h5555;
    b_req = 1; b_wr = 1; b_addr = 8'h31; b_wdata = 16'h6666;
    @(negedge clk);
    chk("rst_mid_ram", {ram_addr, ram_wdata, 6'd0, ram_wr, ram_rd}, 32'd0);
    chk("rst_mid_ctl", {28'd0, a_ack, b_ack, a_dv, b_dv}, 32'd0);
    chk("rst_mid_rdata", {a_rdata, b_rdata}, 32'd0);
    @(negedge clk);
    chk("post_rst_a_first", {30'd0, a_ack, b_ack}, 32'd2);
    @(posedge clk); #1;
    a_req = 0;
    wait_ack(1, lat);
    chk("post_rst_b_lat", lat, 1);
    @(posedge clk); #1;
    b_req = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("final_a_queue", qa.size(), 0);
    chk("final_b_queue", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
